// File: rtl/mult_hilo_seq_if.sv
// Purpose: bus between the HI/LO sequencer and the 32x32 shift-add multiplier.
// Signals:
//   MultCtrl   seq -> mult  run enable
//   MultReset  seq -> mult  clear pulse
//   fatorA     seq -> mult  operand A magnitude
//   fatorB     seq -> mult  operand B magnitude
//   mult_hi    mult -> seq  product HI word
//   mult_lo    mult -> seq  product LO word
//   mult_done  mult -> seq  completion level
// Modports: master = sequencer side, slave = multiplier side.
interface mult_hilo_seq_if;
    logic        MultCtrl;
    logic        MultReset;
    logic [31:0] fatorA;
    logic [31:0] fatorB;
    logic [31:0] mult_hi;
    logic [31:0] mult_lo;
    logic        mult_done;

    modport master (
        output MultCtrl, MultReset, fatorA, fatorB,
        input  mult_hi, mult_lo, mult_done
    );

    modport slave (
        input  MultCtrl, MultReset, fatorA, fatorB,
        output mult_hi, mult_lo, mult_done
    );
endinterface

// File: rtl/mult_hilo_seq.sv
// Purpose: sequences mult/multu through the shift-add multiplier, converting
// signed operands to magnitudes and re-applying the product sign, and owns the
// architectural HI/LO registers (mfhi/mflo/mthi/mtlo). Stalls the control unit
// while an operation is in flight.
// Ports:
//   clk, reset_n         clock, synchronous active-low reset
//   start, signed_op     multiply request and signedness (sampled with start)
//   rs_val, rt_val       operands (sampled with start)
//   mthi_we, mtlo_we     HI/LO write enables, data on wdata (IDLE only)
//   mbus                 multiplier bus (master side)
//   HI, LO               architectural HI/LO
//   busy                 stall, high outside IDLE
//   done                 one-cycle pulse in the FIX cycle
//   timeout_err          sticky abort flag, cleared by the next accepted start
module mult_hilo_seq #(
    parameter int unsigned MIN_RUN = 33,
    parameter int unsigned TIMEOUT = 40
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  signed_op,
    input  logic [31:0]           rs_val,
    input  logic [31:0]           rt_val,
    input  logic                  mthi_we,
    input  logic                  mtlo_we,
    input  logic [31:0]           wdata,
    mult_hilo_seq_if.master       mbus,
    output logic [31:0]           HI,
    output logic [31:0]           LO,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] MIN_C  = CW'(MIN_RUN);
    localparam logic [CW-1:0] LAST_C = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, FIX} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] run_cnt;
    logic [31:0]   fator_a, fator_b;
    logic          result_neg;
    logic          neg_a, neg_b;
    logic          accept, abort;
    logic [63:0]   product, written;

    assign neg_a = signed_op & rs_val[31];
    assign neg_b = signed_op & rt_val[31];

    // mult_done is a level that may be stale from a previous run, so it is
    // only trusted once the multiplier has had MIN_RUN cycles.
    assign accept = (state == RUN) && mbus.mult_done && (run_cnt >= MIN_C);
    // Abort on the last permitted RUN cycle, so exactly TIMEOUT RUN cycles elapse.
    assign abort  = (state == RUN) && !accept && (run_cnt == LAST_C);

    assign product = {mbus.mult_hi, mbus.mult_lo};
    assign written = result_neg ? (~product + 64'd1) : product;

    assign mbus.fatorA = fator_a;
    assign mbus.fatorB = fator_b;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx       = state;
        mbus.MultCtrl  = 1'b0;
        mbus.MultReset = 1'b0;
        busy           = 1'b1;
        done           = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nx = CLEAR;
            end
            CLEAR: begin
                mbus.MultReset = 1'b1;
                state_nx       = RUN;
            end
            RUN: begin
                mbus.MultCtrl = 1'b1;
                if (accept)     state_nx = FIX;
                else if (abort) state_nx = IDLE;
            end
            FIX: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            HI          <= '0;
            LO          <= '0;
            fator_a     <= '0;
            fator_b     <= '0;
            result_neg  <= 1'b0;
            run_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mthi_we) HI <= wdata;
                    if (mtlo_we) LO <= wdata;
                    if (start) begin
                        // Two's-complement negate; 0x80000000 maps to itself,
                        // which is the correct unsigned magnitude.
                        fator_a     <= neg_a ? -rs_val : rs_val;
                        fator_b     <= neg_b ? -rt_val : rt_val;
                        result_neg  <= neg_a ^ neg_b;
                        run_cnt     <= '0;
                        timeout_err <= 1'b0;
                    end
                end
                RUN: begin
                    run_cnt <= run_cnt + 1'b1;
                    if (abort) timeout_err <= 1'b1;
                end
                FIX: begin
                    HI <= written[63:32];
                    LO <= written[31:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_hilo_seq.sv
module tb_mult_hilo_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        signed_op;
    logic [31:0] rs_val, rt_val;
    logic        mthi_we, mtlo_we;
    logic [31:0] wdata;
    logic [31:0] HI, LO;
    logic        busy, done, timeout_err;

    int unsigned checks = 0;
    int unsigned errors = 0;

    mult_hilo_seq_if mbus ();

    mult_hilo_seq #(.MIN_RUN(33), .TIMEOUT(40)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .signed_op   (signed_op),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .mthi_we     (mthi_we),
        .mtlo_we     (mtlo_we),
        .wdata       (wdata),
        .mbus        (mbus.master),
        .HI          (HI),
        .LO          (LO),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Runs one multiply. The bench plays the multiplier: it returns the given
    // magnitude product and raises mult_done 'delay' negedges after CLEAR is
    // observed (0 = already high). exp_cnt is the hand-computed number of
    // cycles from CLEAR to the FIX cycle.
    task automatic do_mult(input string name, input logic sg, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] p_hi, input logic [31:0] p_lo,
                           input logic [31:0] exp_fa, input logic [31:0] exp_fb,
                           input int unsigned delay, input int unsigned exp_cnt,
                           input logic wr, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int unsigned cnt;
        @(negedge clk);
        start = 1'b1; signed_op = sg; rs_val = a; rt_val = b;
        mbus.mult_hi = p_hi; mbus.mult_lo = p_lo;
        if (wr) begin mthi_we = 1'b1; mtlo_we = 1'b1; wdata = 32'h0000DEAD; end
        @(negedge clk);
        start = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0;
        check({name, " clear busy"}, 64'(busy), 64'd1);
        check({name, " clear MultReset"}, 64'(mbus.MultReset), 64'd1);
        check({name, " clear MultCtrl"}, 64'(mbus.MultCtrl), 64'd0);
        check({name, " fatorA"}, 64'(mbus.fatorA), 64'(exp_fa));
        check({name, " fatorB"}, 64'(mbus.fatorB), 64'(exp_fb));
        check({name, " terr cleared"}, 64'(timeout_err), 64'd0);
        if (wr) begin
            check({name, " HI write with start"}, 64'(HI), 64'h0000DEAD);
            check({name, " LO write with start"}, 64'(LO), 64'h0000DEAD);
        end
        cnt = 0;
        mbus.mult_done = (delay == 0);
        while (!done && cnt < 100) begin
            @(negedge clk);
            cnt++;
            if (cnt == delay) mbus.mult_done = 1'b1;
        end
        check({name, " cycles to FIX"}, 64'(cnt), 64'(exp_cnt));
        check({name, " FIX MultCtrl"}, 64'(mbus.MultCtrl), 64'd0);
        @(negedge clk);
        mbus.mult_done = 1'b0;
        check({name, " HI"}, 64'(HI), 64'(exp_hi));
        check({name, " LO"}, 64'(LO), 64'(exp_lo));
        check({name, " done one pulse"}, 64'(done), 64'd0);
        check({name, " busy after FIX"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int unsigned cnt;
        reset_n = 1'b0; start = 1'b0; signed_op = 1'b0; rs_val = '0; rt_val = '0;
        mthi_we = 1'b0; mtlo_we = 1'b0; wdata = '0;
        mbus.mult_hi = '0; mbus.mult_lo = '0; mbus.mult_done = 1'b0;
        repeat (2) @(negedge clk);
        check("rst HI", 64'(HI), 64'd0);
        check("rst LO", 64'(LO), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst MultCtrl", 64'(mbus.MultCtrl), 64'd0);
        check("rst MultReset", 64'(mbus.MultReset), 64'd0);
        check("rst terr", 64'(timeout_err), 64'd0);
        check("rst fatorA", 64'(mbus.fatorA), 64'd0);
        check("rst fatorB", 64'(mbus.fatorB), 64'd0);
        reset_n = 1'b1;

        // mthi / mtlo in IDLE, then both in one cycle
        mthi_we = 1'b1; wdata = 32'h1234;
        @(negedge clk); mthi_we = 1'b0;
        check("mthi HI", 64'(HI), 64'h1234);
        mtlo_we = 1'b1; wdata = 32'h5678;
        @(negedge clk); mtlo_we = 1'b0;
        check("mtlo LO", 64'(LO), 64'h5678);
        check("mtlo HI kept", 64'(HI), 64'h1234);
        mthi_we = 1'b1; mtlo_we = 1'b1; wdata = 32'hAAAA;
        @(negedge clk); mthi_we = 1'b0; mtlo_we = 1'b0;
        check("both HI", 64'(HI), 64'hAAAA);
        check("both LO", 64'(LO), 64'hAAAA);

        // mult_done high in IDLE has no effect
        mbus.mult_done = 1'b1;
        repeat (3) @(negedge clk);
        check("idle done busy", 64'(busy), 64'd0);
        check("idle done pulse", 64'(done), 64'd0);

        // mult_done held high throughout: FIX only after MIN_RUN RUN cycles
        do_mult("multu_ff", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001,
                32'hFFFFFFFF, 32'hFFFFFFFF, 0, 35, 1'b0, 32'hFFFFFFFE, 32'h00000001);
        repeat (3) @(negedge clk);
        check("multu_ff no second done", 64'(done), 64'd0);

        // mult_done arrives late (RUN cycle 36)
        do_mult("mult_m3x5", 1'b1, 32'hFFFFFFFD, 32'd5, 32'h0, 32'd15,
                32'd3, 32'd5, 37, 38, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFF1);

        // most negative squared, with mthi/mtlo coincident with start
        do_mult("mult_min", 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,
                32'h80000000, 32'h80000000, 0, 35, 1'b1, 32'h40000000, 32'h00000000);

        // timeout; start and mthi/mtlo during RUN are ignored
        @(negedge clk);
        start = 1'b1; signed_op = 1'b0; rs_val = 32'd7; rt_val = 32'd9; mbus.mult_done = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (busy && cnt < 100) begin
            @(negedge clk);
            cnt++;
            if (cnt == 5) begin
                start = 1'b1; rs_val = 32'd1; rt_val = 32'd2;
                mthi_we = 1'b1; mtlo_we = 1'b1; wdata = 32'hBEEF;
            end else begin
                start = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0;
            end
        end
        check("tmo cycles to IDLE", 64'(cnt), 64'd41);
        check("tmo terr", 64'(timeout_err), 64'd1);
        check("tmo HI kept", 64'(HI), 64'h40000000);
        check("tmo LO kept", 64'(LO), 64'h0);
        check("tmo fatorA kept", 64'(mbus.fatorA), 64'd7);
        check("tmo fatorB kept", 64'(mbus.fatorB), 64'd9);
        @(negedge clk);
        check("tmo terr sticky", 64'(timeout_err), 64'd1);

        // reset at RUN cycle 10
        start = 1'b1; signed_op = 1'b0; rs_val = 32'd2; rt_val = 32'd3;
        @(negedge clk);
        start = 1'b0;
        check("rr terr cleared", 64'(timeout_err), 64'd0);
        repeat (11) @(negedge clk);
        check("rr in RUN", 64'(mbus.MultCtrl), 64'd1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("rr busy", 64'(busy), 64'd0);
        check("rr MultCtrl", 64'(mbus.MultCtrl), 64'd0);
        check("rr HI", 64'(HI), 64'd0);
        check("rr LO", 64'(LO), 64'd0);
        check("rr fatorA", 64'(mbus.fatorA), 64'd0);

        do_mult("multu_6x7", 1'b0, 32'd6, 32'd7, 32'h0, 32'd42,
                32'd6, 32'd7, 0, 35, 1'b0, 32'h0, 32'd42);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
